// File: rtl/binario_a_bcd_pkg.sv
// rtl/binario_a_bcd_pkg.sv - shared types, constants and sizing helper for the binary-to-BCD unit
// Purpose : BCD digit type, double-dabble correction constants, digit-count helper.
// Ports   : none (package).
package binario_a_bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    // A digit >= 5 would become >= 10 after the next shift, so it is
    // pre-corrected by +3 to carry into the next digit instead.
    localparam bcd_digit_t BCD_ADD3_THRESH = 4'd5;
    localparam bcd_digit_t BCD_ADD3        = 4'd3;

    // Number of decimal digits needed to represent 2**in_w - 1.
    function automatic int digits_needed(input int in_w);
        int max_v;
        int d;
        max_v = (1 << in_w) - 1;
        d     = 1;
        for (int k = 0; k < 10; k++) begin
            if (max_v >= 10) begin
                max_v = max_v / 10;
                d     = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_core.sv
// rtl/bin2bcd_core.sv - combinational shift-add-3 binary-to-BCD converter
// Purpose : converts an unsigned IN_W-bit value into BCD_DIGITS packed BCD digits.
// Ports   : bin_in  [IN_W-1:0]         unsigned binary value
//           bcd_out [4*BCD_DIGITS-1:0] packed BCD, digit 0 in the low nibble
module bin2bcd_core
    import binario_a_bcd_pkg::*;
#(
    parameter int IN_W       = 4,
    parameter int BCD_DIGITS = 2
) (
    input  logic [IN_W-1:0]         bin_in,
    output logic [4*BCD_DIGITS-1:0] bcd_out
);

    localparam int OUT_W = 4 * BCD_DIGITS;

    logic [OUT_W-1:0] acc;
    bcd_digit_t       digit;

    // One correction-then-shift step per input bit, MSB first. The shift
    // brings the next binary bit into the ones digit.
    always_comb begin
        acc   = '0;
        digit = '0;
        for (int i = IN_W - 1; i >= 0; i--) begin
            for (int d = 0; d < BCD_DIGITS; d++) begin
                digit = acc[4*d +: 4];
                if (digit >= BCD_ADD3_THRESH) begin
                    acc[4*d +: 4] = digit + BCD_ADD3;
                end
            end
            acc = {acc[OUT_W-2:0], bin_in[i]};
        end
        bcd_out = acc;
    end

endmodule

// File: rtl/binario_a_bcd_unit.sv
// rtl/binario_a_bcd_unit.sv - registered single-stage binary-to-BCD converter with valid flag
// Purpose : double-dabble core followed by one output register stage.
// Ports   : clk          system clock, rising edge
//           rst          asynchronous active-high reset
//           in_valid     binary_input is sampled when high
//           binary_input [IN_W-1:0] unsigned value
//           bcd_output   [4*BCD_DIGITS-1:0] registered BCD result
//           out_valid    bcd_output was updated on the last edge
module binario_a_bcd_unit
    import binario_a_bcd_pkg::*;
#(
    parameter int IN_W       = 4,
    parameter int BCD_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [IN_W-1:0]         binary_input,
    output logic [4*BCD_DIGITS-1:0] bcd_output,
    output logic                    out_valid
);

    localparam int OUT_W = 4 * BCD_DIGITS;

    if (IN_W < 1 || IN_W > 8) begin : g_bad_in_w
        $error("binario_a_bcd_unit: IN_W must be in 1..8");
    end

    if (BCD_DIGITS < digits_needed(IN_W)) begin : g_bad_digits
        $error("binario_a_bcd_unit: BCD_DIGITS too small for 2**IN_W-1");
    end

    logic [OUT_W-1:0] core_bcd;
    logic [OUT_W-1:0] bcd_d, bcd_q;
    logic             out_valid_d, out_valid_q;

    bin2bcd_core #(
        .IN_W       (IN_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_core (
        .bin_in  (binary_input),
        .bcd_out (core_bcd)
    );

    // The result register holds its value when no new input arrives so the
    // downstream display does not blank between samples.
    always_comb begin
        bcd_d       = bcd_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            bcd_d = core_bcd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            bcd_q       <= bcd_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bcd_output = bcd_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_binario_a_bcd_unit.sv
// tb/tb_binario_a_bcd_unit.sv - self-checking bench for binario_a_bcd_unit
module tb_binario_a_bcd_unit;

    localparam int IN_W       = 4;
    localparam int BCD_DIGITS = 2;
    localparam int OUT_W      = 4 * BCD_DIGITS;

    logic             clk          = 1'b0;
    logic             rst          = 1'b1;
    logic             in_valid     = 1'b0;
    logic [IN_W-1:0]  binary_input = '0;
    logic [OUT_W-1:0] bcd_output;
    logic             out_valid;

    int n_cmp  = 0;
    int n_fail = 0;
    logic check_en = 1'b0;

    logic [OUT_W-1:0] exp_bcd   = '0;
    logic             exp_valid = 1'b0;

    binario_a_bcd_unit #(
        .IN_W       (IN_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .binary_input (binary_input),
        .bcd_output   (bcd_output),
        .out_valid    (out_valid)
    );

    always #5 clk = ~clk;

    // Decimal digits of v by division, packed one per nibble.
    function automatic logic [OUT_W-1:0] bcd_of(input int v);
        logic [OUT_W-1:0] r;
        int               x;
        r = '0;
        x = v;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: registered conversion with hold-on-idle and async clear.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_bcd   <= '0;
            exp_valid <= 1'b0;
        end else if (in_valid) begin
            exp_bcd   <= bcd_of(int'(binary_input));
            exp_valid <= 1'b1;
        end else begin
            exp_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("cyc_bcd", 32'(bcd_output), 32'(exp_bcd));
            check("cyc_valid", 32'(out_valid), 32'(exp_valid));
        end
    end

    task automatic step(input logic vld, input int v, input logic [7:0] eb, input logic ev,
                        input string name);
        in_valid     = vld;
        binary_input = IN_W'(v);
        @(posedge clk);
        #1;
        check({name, "_bcd"}, 32'(bcd_output), 32'(eb));
        check({name, "_valid"}, 32'(out_valid), 32'(ev));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        check("rst_bcd", 32'(bcd_output), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        check_en = 1'b1;

        // model pins
        check("model_0", 32'(bcd_of(0)), 32'h00);
        check("model_9", 32'(bcd_of(9)), 32'h09);
        check("model_12", 32'(bcd_of(12)), 32'h12);

        // sweep 0..9
        for (int v = 0; v < 10; v++) begin
            step(1'b1, v, 8'(v), 1'b1, "sweep");
        end

        // above 9
        step(1'b1, 10, 8'h10, 1'b1, "wrap10");
        step(1'b1, 11, 8'h11, 1'b1, "wrap11");
        step(1'b1, 15, 8'h15, 1'b1, "wrap15");

        // hold
        step(1'b1, 7, 8'h07, 1'b1, "hold_load");
        step(1'b0, 3, 8'h07, 1'b0, "hold_idle");
        step(1'b0, 3, 8'h07, 1'b0, "hold_idle2");

        // back-to-back
        step(1'b1, 9, 8'h09, 1'b1, "b2b_9");
        step(1'b1, 10, 8'h10, 1'b1, "b2b_10");

        // mid-stream async reset
        in_valid     = 1'b1;
        binary_input = 4'd9;
        @(posedge clk);
        #1;
        check("pre_rst_bcd", 32'(bcd_output), 32'h09);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_bcd", 32'(bcd_output), 32'h0);
        check("async_rst_valid", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1;
        check("held_rst_bcd", 32'(bcd_output), 32'h0);
        check("held_rst_valid", 32'(out_valid), 32'h0);
        rst = 1'b0;
        step(1'b1, 9, 8'h09, 1'b1, "post_rst");

        // exhaustive arithmetic property
        for (int v = 0; v < 16; v++) begin
            in_valid     = 1'b1;
            binary_input = 4'(v);
            @(posedge clk);
            #1;
            check("exh_value", 32'(int'(bcd_output[7:4]) * 10 + int'(bcd_output[3:0])), 32'(v));
            check("exh_tens_legal", 32'(bcd_output[7:4] <= 4'd9), 32'h1);
            check("exh_ones_legal", 32'(bcd_output[3:0] <= 4'd9), 32'h1);
        end

        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
